// File: rtl/rf_writeback_unit.sv
// Write-side sequencer for the 16x16 register bank: queues ALU/load results in an
// in-order FIFO and drains one write per clock. Optional forwarding: RF_WB_FWD_EN.
module rf_writeback_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_W-1:0]      alu_reg,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [ADDR_W-1:0]      mem_reg,
  input  logic [DATA_W-1:0]      mem_data,
  output logic [ADDR_W-1:0]      regC,
  output logic [DATA_W-1:0]      dado,
  output logic                   RW,
  output logic [2**ADDR_W-1:0]   busy,
`ifdef RF_WB_FWD_EN
  input  logic [ADDR_W-1:0]      fwd_a_reg,
  input  logic [ADDR_W-1:0]      fwd_b_reg,
  output logic                   fwd_a_hit,
  output logic                   fwd_b_hit,
  output logic [DATA_W-1:0]      fwd_a_data,
  output logic [DATA_W-1:0]      fwd_b_data,
`endif
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_M1   = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_M2   = CNT_W'(DEPTH - 2);

  logic [ADDR_W-1:0] ent_reg  [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [PTR_W-1:0]  head, tail, tail_next, alu_slot;
  logic [CNT_W-1:0]  count, count_next;
  logic              mem_push, alu_push, pop;

  assign fifo_count = count;

  // Readiness looks only at the registered count; a same-cycle pop is not credited,
  // which also guarantees pushes never overwrite the entry being popped.
  assign mem_ready = rst_n & (count < CNT_FULL);
  assign alu_ready = rst_n & ((count <= CNT_M2) | ((count == CNT_M1) & ~mem_valid));

  assign mem_push = mem_valid & mem_ready;
  assign alu_push = alu_valid & alu_ready;
  assign pop      = (count != '0);

  always_comb begin
    alu_slot   = mem_push ? tail + PTR_W'(1) : tail;
    tail_next  = tail + PTR_W'(mem_push) + PTR_W'(alu_push);
    count_next = count + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (mem_push) begin
      ent_reg[tail]  <= mem_reg;
      ent_data[tail] <= mem_data;
    end
    if (alu_push) begin
      ent_reg[alu_slot]  <= alu_reg;
      ent_data[alu_slot] <= alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      RW    <= 1'b0;
      regC  <= '0;
      dado  <= '0;
    end else begin
      tail  <= tail_next;
      count <= count_next;
      if (pop) begin
        RW   <= 1'b1;
        regC <= ent_reg[head];
        dado <= ent_data[head];
        head <= head + PTR_W'(1);
      end else begin
        RW <= 1'b0;
      end
    end
  end

  always_comb begin
    busy = '0;
    if (RW)
      busy[regC] = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count)
        busy[ent_reg[head + PTR_W'(i)]] = 1'b1;
    end
  end

`ifdef RF_WB_FWD_EN
  // Scan oldest to youngest so later (younger) matches override earlier ones;
  // the output stage is seeded first as the lowest priority.
  function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] r);
    logic [DATA_W:0] res;
    res = '0;
    if (RW && (regC == r))
      res = {1'b1, dado};
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (ent_reg[head + PTR_W'(i)] == r))
        res = {1'b1, ent_data[head + PTR_W'(i)]};
    end
    return res;
  endfunction

  always_comb begin
    {fwd_a_hit, fwd_a_data} = fwd_lookup(fwd_a_reg);
    {fwd_b_hit, fwd_b_data} = fwd_lookup(fwd_b_reg);
  end
`endif

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Directed bench for rf_writeback_unit (DEPTH=4): latency, ordering, readiness,
// async reset and, when RF_WB_FWD_EN is defined, forwarding.
module tb_rf_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [3:0]  alu_reg, mem_reg, regC;
  logic [15:0] alu_data, mem_data, dado;
  logic        RW;
  logic [15:0] busy;
  logic [2:0]  fifo_count;
`ifdef RF_WB_FWD_EN
  logic [3:0]  fwd_a_reg, fwd_b_reg;
  logic        fwd_a_hit, fwd_b_hit;
  logic [15:0] fwd_a_data, fwd_b_data;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // bench-side model of the FIFO: {reg, data} per entry, oldest first
  logic [19:0] q[$];
  int          mcnt = 0;

  rf_writeback_unit #(.DATA_W(16), .ADDR_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .regC(regC), .dado(dado), .RW(RW), .busy(busy),
`ifdef RF_WB_FWD_EN
    .fwd_a_reg(fwd_a_reg), .fwd_b_reg(fwd_b_reg),
    .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
    .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
`endif
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One modelled cycle: drive inputs, check readiness, clock, check write port.
  task automatic run_cycle(input string tag, input logic mv, input logic [3:0] mr,
                           input logic [15:0] md, input logic av,
                           input logic [3:0] ar, input logic [15:0] ad);
    logic        er_m, er_a, acc_m, acc_a, pp;
    logic [19:0] exp_out;
    mem_valid = mv; mem_reg = mr; mem_data = md;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    #1;
    er_m = (mcnt < 4);
    er_a = (mcnt <= 2) || ((mcnt == 3) && !mv);
    chk({tag, "_mem_ready"}, mem_ready, er_m);
    chk({tag, "_alu_ready"}, alu_ready, er_a);
    acc_m   = mv && er_m;
    acc_a   = av && er_a;
    pp      = (mcnt > 0);
    exp_out = '0;
    if (pp) exp_out = q.pop_front();
    if (acc_m) q.push_back({mr, md});
    if (acc_a) q.push_back({ar, ad});
    mcnt = mcnt + int'(acc_m) + int'(acc_a) - int'(pp);
    tick();
    chk({tag, "_RW"}, RW, pp);
    if (pp) begin
      chk({tag, "_regC"}, regC, exp_out[19:16]);
      chk({tag, "_dado"}, dado, exp_out[15:0]);
    end
    chk({tag, "_count"}, fifo_count, mcnt);
  endtask

  initial begin
    logic [19:0] pat_m, pat_a;
    rst_n = 1'b0;
    alu_valid = 1'b0; mem_valid = 1'b0;
    alu_reg = '0; mem_reg = '0; alu_data = '0; mem_data = '0;
`ifdef RF_WB_FWD_EN
    fwd_a_reg = '0; fwd_b_reg = '0;
`endif
    #2;
    chk("rst_RW", RW, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_regC", regC, 0);
    chk("rst_dado", dado, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    #5 rst_n = 1'b1;

    // single ALU push into an empty FIFO
    alu_valid = 1'b1; alu_reg = 4'd3; alu_data = 16'h1234;
    #1 chk("a_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("a_count1", fifo_count, 1);
    chk("a_RW0", RW, 0);
    chk("a_busy3_c1", busy[3], 1);
    tick();
    chk("a_RW1", RW, 1);
    chk("a_regC", regC, 3);
    chk("a_dado", dado, 16'h1234);
    chk("a_busy3_c2", busy[3], 1);
    tick();
    chk("a_RW_off", RW, 0);
    chk("a_busy_clear", busy, 0);
    chk("a_regC_hold", regC, 3);
    chk("a_dado_hold", dado, 16'h1234);

    // simultaneous mem + alu to the same register: mem is older
    mem_valid = 1'b1; mem_reg = 4'd5; mem_data = 16'hAAAA;
    alu_valid = 1'b1; alu_reg = 4'd5; alu_data = 16'h5555;
    #1;
    chk("b_mem_ready", mem_ready, 1);
    chk("b_alu_ready", alu_ready, 1);
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    chk("b_count2", fifo_count, 2);
    chk("b_busy5", busy, 16'h0020);
    tick();
    chk("b_RW1", RW, 1);
    chk("b_dado1", dado, 16'hAAAA);
    tick();
    chk("b_RW2", RW, 1);
    chk("b_dado2", dado, 16'h5555);
    chk("b_busy5_last", busy[5], 1);
    tick();
    chk("b_RW_off", RW, 0);
    chk("b_busy_clear", busy, 0);

`ifdef RF_WB_FWD_EN
    // two pending writes to r7: youngest wins, then falls back to the output stage
    mem_valid = 1'b1; mem_reg = 4'd7; mem_data = 16'h0001;
    alu_valid = 1'b1; alu_reg = 4'd7; alu_data = 16'h0002;
    fwd_a_reg = 4'd7; fwd_b_reg = 4'd8;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    chk("f_a_hit", fwd_a_hit, 1);
    chk("f_a_data", fwd_a_data, 16'h0002);
    chk("f_b_hit", fwd_b_hit, 0);
    chk("f_b_data", fwd_b_data, 0);
    tick();
    chk("f_dado_old", dado, 16'h0001);
    chk("f_a_data_q", fwd_a_data, 16'h0002);
    tick();
    chk("f_a_hit_out", fwd_a_hit, 1);
    chk("f_a_data_out", fwd_a_data, 16'h0002);
    tick();
    chk("f_a_hit_none", fwd_a_hit, 0);
    chk("f_a_data_none", fwd_a_data, 0);
`endif

    // fill: both producers held valid; count climbs 0 -> 2 -> 3 and stays
    for (int i = 0; i < 5; i++)
      run_cycle("fill", 1'b1, 4'(i), 16'hC000 + 16'(i), 1'b1, 4'(i + 8), 16'hD000 + 16'(i));
    chk("fill_cnt3", fifo_count, 3);
    mem_valid = 1'b1; #1;
    chk("fill_alu_block", alu_ready, 0);
    chk("fill_mem_ok", mem_ready, 1);
    for (int i = 0; i < 4; i++)
      run_cycle("drain1", 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);

    // 20 mixed cycles scoreboarded against the model
    pat_m = 20'b1101_0111_1011_0110_1101;
    pat_a = 20'b1011_1110_0111_1101_0110;
    for (int i = 0; i < 20; i++)
      run_cycle("mix", pat_m[i], 4'(i), 16'hA000 + 16'(i),
                pat_a[i], 4'(i + 1), 16'h5000 + 16'(i));
    for (int i = 0; i < 5; i++)
      run_cycle("drain2", 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    chk("drain_empty", fifo_count, 0);

    // alternating single pushes: RW stays high, count never exceeds 1
    for (int i = 0; i < 8; i++) begin
      run_cycle("alt", (i % 2) == 0, 4'd2, 16'h0100 + 16'(i),
                (i % 2) == 1, 4'd9, 16'h0200 + 16'(i));
      if (i > 0) chk("alt_RW_hold", RW, 1);
      chk("alt_cnt_le1", fifo_count <= 3'd1, 1);
    end
    run_cycle("alt_end", 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    run_cycle("alt_end", 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);

    // async reset with 3 entries queued
    run_cycle("prerst", 1'b1, 4'd1, 16'hE001, 1'b1, 4'd2, 16'hE002);
    run_cycle("prerst", 1'b1, 4'd3, 16'hE003, 1'b1, 4'd4, 16'hE004);
    chk("prerst_cnt3", fifo_count, 3);
    mem_valid = 1'b0; alu_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_RW", RW, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_alu_ready", alu_ready, 0);
    chk("arst_mem_ready", mem_ready, 0);
    q.delete();
    mcnt = 0;
    #10 rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      run_cycle("postrst", 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
